led_scanner: RTL and testbench
==============================

// Module: led_scanner
// PURPOSE
//  Parametrised LED position scanner for the board LED bank; the generalised successor of the fixed 10-LED bounce.
//  A single-clock prescaler produces a step enable, so no derived clocks are used.
//  Generalised in LED count, prescale width and run-time speed, with bounce/wrap/bar-fill/off modes.
//  Sits directly between the board clock and the LED pins; pos/dir/tick are exported for other display logic.
// PARAMETERS
//  N_LEDS  10  number of LEDs driven; legal range 2..64
//  DIV_W   21  prescaler width; slowest step period = 2^DIV_W clk cycles; legal range 4..32
//  POS_W   $clog2(N_LEDS)  width of pos; localparam, not overridable
// PORTS
//  clk    in   1       board clock; all logic on posedge
//  rst_n  in   1       synchronous reset, active-low
//  en     in   1       1 = run; 0 = freeze prescaler and pattern
//  mode   in   2       00 BOUNCE, 01 WRAP, 10 FILL, 11 OFF
//  speed  in   2       step period = 2^(DIV_W-speed) cycles; 0 = slowest
//  led    out  N_LEDS  LED drive pattern, registered
//  pos    out  POS_W   current position 0..N_LEDS-1, registered
//  dir    out  1       1 = moving up (toward LED N-1), registered
//  tick   out  1       1-cycle pulse, high in the cycle the new pos/led first appear
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): cnt=0, pos=0, dir=1, led=1 (LED0 on), tick=0, mode_q=00. Reset has priority over all other events.
//  Prescaler: DIV_W-bit cnt increments by 1 each cycle while en=1 and holds while en=0.
//   step = en & (cnt[DIV_W-1-speed:0] == all ones). On the step edge, cnt wraps naturally (+1).
//   A speed change mid-count needs no flush; the next step follows the new speed.
//  Step: on the step edge, pos, dir and led update together and tick<=1. Otherwise tick<=0.
//   Latency is one step per 2^(DIV_W-speed) cycles; no skipped or double steps.
//  Mode change: mode_q registers mode each cycle. If mode!=mode_q, the next edge sets cnt=0, pos=0, dir=1, tick=0,
//   and led=decode(0, new mode). This overrides a coincident step.
//  BOUNCE: dir=1 and pos<N-1: pos+1. At pos=N-1 on a step: dir<=0 and pos<=N-2 on the same step (no dwell).
//   Mirror behaviour applies at 0: dir<=1 and pos<=1. Full cycle = 2*(N-1) steps.
//   led = one-hot(pos).
//  WRAP: pos+1; N-1 -> 0 on the same step. dir is held at 1. led = one-hot(pos).
//  FILL: pos advances as in WRAP. led = bits [pos:0] set (bar graph); pos=N-1 gives all ones, and the next step gives 1.
//  OFF: led = 0. pos, dir and cnt keep running so a later switch gets a clean restart via the mode-change rule.
//  en=0: led/pos/dir/cnt are held and tick=0. Resuming continues the count from where it stopped.
//  Out-of-range pos (values >=N_LEDS when N_LEDS is not a power of 2) is unreachable. The decode drives led=0 for it defensively.
// TESTING (bench uses N_LEDS=10, DIV_W=4)
//  1 Reset: rst_n=0 for 3 cycles mid-sweep -> next edge led=10'h001, pos=0, dir=1, tick=0.
//  2 BOUNCE, speed=0: ticks exactly every 16 cycles.
//    pos sequence is 0,1..9,8..1,0,1. At 9 the next step is 8 with dir=0. Period is 18 steps.
//  3 WRAP, speed=2: ticks every 4 cycles. pos 9 -> 0 and led 10'h200 -> 10'h001. dir stays 1.
//  4 FILL: pos=3 -> led=10'h00F. pos=9 -> 10'h3FF, then next step 10'h001. OFF -> led=0 while tick continues.
//  5 en=0 for 50 cycles at pos=5 -> outputs frozen with no tick.
//    After en=1, the first tick comes (16 - cycles already counted) cycles later with pos=6.
//  6 mode change BOUNCE->WRAP at pos=7, dir=0, coincident with a step: the next edge gives pos=0, dir=1, tick=0.
//    The following tick comes 16 cycles later with pos=1.

Source files
------------

// File: rtl/led_scanner.sv
// LED position scanner: a prescaled step enable drives a bounce/wrap/bar-fill/off
// pattern over N_LEDS outputs. All state is in the clk domain.
module led_scanner #(
  parameter  int N_LEDS = 10,
  parameter  int DIV_W  = 21,
  localparam int POS_W  = $clog2(N_LEDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [1:0]        speed,
  output logic [N_LEDS-1:0] led,
  output logic [POS_W-1:0]  pos,
  output logic              dir,
  output logic              tick
);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_FILL   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] POS_ZERO = '0;
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              tick_q, tick_d;
  mode_e             mode_q, mode_d;

  logic [DIV_W-1:0]  step_mask;
  logic              step;
  logic              mode_change;
  logic [POS_W-1:0]  pos_step;
  logic              dir_step;

  // Positions at or beyond N_LEDS cannot occur; they decode to all-off.
  function automatic logic [N_LEDS-1:0] decode(input logic [POS_W-1:0] p, input mode_e m);
    logic [N_LEDS-1:0] r;
    r = '0;
    if (int'(p) < N_LEDS) begin
      for (int i = 0; i < N_LEDS; i++) begin
        case (m)
          MODE_BOUNCE, MODE_WRAP: r[i] = (POS_W'(i) == p);
          MODE_FILL:              r[i] = (POS_W'(i) <= p);
          default:                r[i] = 1'b0;
        endcase
      end
    end
    return r;
  endfunction

  // Low (DIV_W-speed) bits all ones marks the last cycle of a step period.
  assign step_mask   = {DIV_W{1'b1}} >> speed;
  assign step        = en && ((cnt_q & step_mask) == step_mask);
  assign mode_change = (mode_e'(mode) != mode_q);

  always_comb begin
    pos_step = pos_q;
    dir_step = 1'b1;
    if (mode_q == MODE_BOUNCE) begin
      if (dir_q) begin
        if (pos_q == POS_MAX) begin
          pos_step = POS_MAX - POS_ONE;
          dir_step = 1'b0;
        end else begin
          pos_step = pos_q + POS_ONE;
        end
      end else begin
        if (pos_q == POS_ZERO) begin
          pos_step = POS_ONE;
        end else begin
          pos_step = pos_q - POS_ONE;
          dir_step = 1'b0;
        end
      end
    end else begin
      pos_step = (pos_q == POS_MAX) ? POS_ZERO : pos_q + POS_ONE;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    led_d  = led_q;
    tick_d = 1'b0;
    mode_d = mode_e'(mode);
    if (mode_change) begin
      // A mode switch restarts the pattern and swallows any coincident step.
      cnt_d = '0;
      pos_d = POS_ZERO;
      dir_d = 1'b1;
      led_d = decode(POS_ZERO, mode_e'(mode));
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
      if (step) begin
        pos_d  = pos_step;
        dir_d  = dir_step;
        led_d  = decode(pos_step, mode_q);
        tick_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pos_q  <= POS_ZERO;
      dir_q  <= 1'b1;
      led_q  <= N_LEDS'(1);
      tick_q <= 1'b0;
      mode_q <= MODE_BOUNCE;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      tick_q <= tick_d;
      mode_q <= mode_d;
    end
  end

  assign led  = led_q;
  assign pos  = pos_q;
  assign dir  = dir_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner with N_LEDS=10, DIV_W=4: tick spacing,
// pattern sequences per mode, reset, freeze/resume and mode-change restart.
module tb_led_scanner;

  localparam int N  = 10;
  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [1:0] speed = 2'b00;
  logic [9:0] led;
  logic [3:0] pos;
  logic       dir;
  logic       tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_scanner #(.N_LEDS(N), .DIV_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .speed (speed),
    .led   (led),
    .pos   (pos),
    .dir   (dir),
    .tick  (tick)
  );

  typedef struct {
    logic [1:0] mode;
    logic [1:0] speed;
    int         gap;
    int         pos;
    logic       dir;
    logic [9:0] led;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the next tick; a missing tick shows up as a wrong gap.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < 100);
  endtask

  function automatic logic [9:0] onehot(input int p);
    logic [9:0] one;
    one = 10'd1;
    return one << p;
  endfunction

  function automatic logic [9:0] bar(input int p);
    logic [9:0] one;
    one = 10'd1;
    return (one << (p + 1)) - one;
  endfunction

  task automatic add(input logic [1:0] m, input logic [1:0] s, input int g,
                     input int p, input logic d, input logic [9:0] l);
    vecs.push_back('{m, s, g, p, d, l});
  endtask

  task automatic run_table(input string tag);
    int n;
    foreach (vecs[i]) begin
      mode  = vecs[i].mode;
      speed = vecs[i].speed;
      wait_tick(n);
      $display("%s[%0d] gap=%0d pos=%0d dir=%0b led=%03h", tag, i, n, pos, dir, led);
      check({tag, "_gap"}, 64'(n), 64'(vecs[i].gap));
      check({tag, "_pos"}, 64'(pos), 64'(vecs[i].pos));
      check({tag, "_dir"}, 64'(dir), 64'(vecs[i].dir));
      check({tag, "_led"}, 64'(led), 64'(vecs[i].led));
    end
    vecs.delete();
  endtask

  task automatic check_state(input string tag, input int p, input logic d,
                             input logic [9:0] l, input logic t);
    $display("%s pos=%0d dir=%0b led=%03h tick=%0b", tag, pos, dir, led, tick);
    check({tag, "_pos"}, 64'(pos), 64'(p));
    check({tag, "_dir"}, 64'(dir), 64'(d));
    check({tag, "_led"}, 64'(led), 64'(l));
    check({tag, "_tick"}, 64'(tick), 64'(t));
  endtask

  initial begin
    int n;
    int frozen_ticks;

    // Power-on reset
    rst_n = 1'b0;
    repeat (3) cyc();
    check_state("reset0", 0, 1'b1, 10'h001, 1'b0);
    rst_n = 1'b1;

    // BOUNCE, speed 0: full 18-step period plus one
    for (int p = 1; p <= 9; p++) add(2'b00, 2'b00, 16, p, 1'b1, onehot(p));
    for (int p = 8; p >= 0; p--) add(2'b00, 2'b00, 16, p, 1'b0, onehot(p));
    add(2'b00, 2'b00, 16, 1, 1'b1, onehot(1));
    run_table("bounce");

    // Reset mid-sweep
    repeat (5) cyc();
    rst_n = 1'b0;
    repeat (3) cyc();
    check_state("reset1", 0, 1'b1, 10'h001, 1'b0);
    rst_n = 1'b1;

    // WRAP, speed 2
    mode  = 2'b01;
    speed = 2'b10;
    cyc();
    check_state("wrap_entry", 0, 1'b1, 10'h001, 1'b0);
    for (int p = 1; p <= 9; p++) add(2'b01, 2'b10, 4, p, 1'b1, onehot(p));
    add(2'b01, 2'b10, 4, 0, 1'b1, 10'h001);
    add(2'b01, 2'b10, 4, 1, 1'b1, 10'h002);
    run_table("wrap");

    // FILL, speed 2
    mode = 2'b10;
    cyc();
    check_state("fill_entry", 0, 1'b1, 10'h001, 1'b0);
    for (int p = 1; p <= 9; p++) add(2'b10, 2'b10, 4, p, 1'b1, bar(p));
    add(2'b10, 2'b10, 4, 0, 1'b1, 10'h001);
    run_table("fill");

    // OFF: LEDs dark, ticks and position keep running
    mode = 2'b11;
    cyc();
    check_state("off_entry", 0, 1'b1, 10'h000, 1'b0);
    for (int p = 1; p <= 3; p++) add(2'b11, 2'b10, 4, p, 1'b1, 10'h000);
    run_table("off");

    // Freeze at pos 5, six cycles into the step period
    mode  = 2'b00;
    speed = 2'b00;
    cyc();
    check_state("bounce_entry", 0, 1'b1, 10'h001, 1'b0);
    for (int p = 1; p <= 5; p++) add(2'b00, 2'b00, 16, p, 1'b1, onehot(p));
    run_table("pre_freeze");
    repeat (6) cyc();
    en = 1'b0;
    frozen_ticks = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (tick) frozen_ticks++;
    end
    check("freeze_ticks", 64'(frozen_ticks), 64'd0);
    check_state("frozen", 5, 1'b1, 10'h020, 1'b0);
    en = 1'b1;
    wait_tick(n);
    $display("resume gap=%0d pos=%0d led=%03h", n, pos, led);
    check("resume_gap", 64'(n), 64'd10);
    check("resume_pos", 64'(pos), 64'd6);
    check("resume_led", 64'(led), 64'h040);

    // Mode change coincident with a step at pos 7 going down
    add(2'b00, 2'b00, 16, 7, 1'b1, onehot(7));
    add(2'b00, 2'b00, 16, 8, 1'b1, onehot(8));
    add(2'b00, 2'b00, 16, 9, 1'b1, onehot(9));
    add(2'b00, 2'b00, 16, 8, 1'b0, onehot(8));
    add(2'b00, 2'b00, 16, 7, 1'b0, onehot(7));
    run_table("pre_switch");
    repeat (15) cyc();
    check("pre_switch_tick", 64'(tick), 64'd0);
    mode = 2'b01;
    cyc();
    check_state("switch", 0, 1'b1, 10'h001, 1'b0);
    wait_tick(n);
    $display("post_switch gap=%0d pos=%0d dir=%0b led=%03h", n, pos, dir, led);
    check("post_switch_gap", 64'(n), 64'd16);
    check("post_switch_pos", 64'(pos), 64'd1);
    check("post_switch_led", 64'(led), 64'h002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
